// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush arbiter: per-register stall and flush vectors, a flush tail
// stretched over FLUSH_CYC cycles, saturating perf counters and a stall watchdog.
module pipe_hold_ctrl #(
    parameter int STAGES    = 5,
    parameter int ID_IDX    = 2,
    parameter int EX_IDX    = 3,
    parameter int MEM_IDX   = 4,
    parameter int FLUSH_CYC = 1,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                prd_jump_i,
    input  logic                ex_hold_i,
    input  logic                ex_jump_i,
    input  logic                mem_stall_i,
    input  logic                trap_i,
    input  logic                clr_i,
    output logic [STAGES-1:0]   stall_o,
    output logic [STAGES-1:0]   flush_o,
    output logic                hold_timeout_o,
    output logic [CNT_W-1:0]    stall_cyc_o,
    output logic [CNT_W-1:0]    flush_cyc_o
);

    localparam int TW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int RW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t             state_reg, state_next;
    logic [TW-1:0]      tcnt_reg, tcnt_next;
    logic [STAGES-1:0]  tail_reg, tail_next;
    logic [RW-1:0]      run_reg;
    logic               timeout_reg;
    logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;

    logic [STAGES-1:0]  trap_fl, jmp_fl, mst_st, mst_fl, exh_st, exh_fl, prd_fl;
    logic [STAGES-1:0]  win_st, win_fl, fl_all;
    logic               restart;

    // Constant request patterns, one bit per pipeline register.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_pat
            assign trap_fl[gi] = (gi >= 1) && (gi <= MEM_IDX);
            assign jmp_fl[gi]  = (gi >= 1) && (gi < EX_IDX);
            assign mst_st[gi]  = (gi < MEM_IDX);
            assign mst_fl[gi]  = (gi == MEM_IDX);
            assign exh_st[gi]  = (gi < EX_IDX);
            assign exh_fl[gi]  = (gi == EX_IDX);
            assign prd_fl[gi]  = (gi == 1);
        end
    endgenerate

    always_comb begin
        win_st     = '0;
        win_fl     = '0;
        restart    = 1'b0;
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        tail_next  = tail_reg;

        if (trap_i) begin
            win_fl  = trap_fl;
            restart = 1'b1;
        end else if (ex_jump_i) begin
            win_fl  = jmp_fl;
            restart = 1'b1;
        end else if (mem_stall_i) begin
            win_st = mst_st;
            win_fl = mst_fl;
        end else if (ex_hold_i) begin
            win_st = exh_st;
            win_fl = exh_fl;
        end else if (prd_jump_i && state_reg == IDLE) begin
            win_fl = prd_fl;
        end

        fl_all    = win_fl | ((state_reg == FLUSH) ? tail_reg : '0);
        fl_all[0] = 1'b0;

        if (!rstn) begin
            flush_o = '0;
            stall_o = '0;
        end else begin
            flush_o = fl_all;
            stall_o = win_st & ~fl_all;
        end

        if (restart && FLUSH_CYC > 1) begin
            state_next = FLUSH;
            tcnt_next  = TW'(FLUSH_CYC - 1);
            tail_next  = win_fl;
        end else if (state_reg == FLUSH) begin
            tcnt_next = tcnt_reg - TW'(1);
            if (tcnt_reg == TW'(1)) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            tcnt_reg      <= '0;
            tail_reg      <= '0;
            run_reg       <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            tail_reg  <= tail_next;
            if (clr_i) begin
                run_reg       <= '0;
                timeout_reg   <= 1'b0;
                stall_cnt_reg <= '0;
                flush_cnt_reg <= '0;
            end else begin
                if (|stall_o) begin
                    if (run_reg != RW'(TIMEOUT)) begin
                        run_reg <= run_reg + RW'(1);
                    end
                    // Flag rises on the edge where the run reaches TIMEOUT.
                    if (run_reg == RW'(TIMEOUT - 1)) begin
                        timeout_reg <= 1'b1;
                    end
                    if (stall_cnt_reg != '1) begin
                        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
                    end
                end else begin
                    run_reg <= '0;
                end
                if (|flush_o && flush_cnt_reg != '1) begin
                    flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign hold_timeout_o = timeout_reg;
    assign stall_cyc_o    = stall_cnt_reg;
    assign flush_cyc_o    = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: directed scenarios plus random requests, checked every
// cycle against a cycle-count reference model of the hold/flush rules.
module tb_pipe_hold_ctrl;

    localparam int STAGES    = 5;
    localparam int FLUSH_CYC = 3;
    localparam int TIMEOUT   = 8;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn, prd_jump_i, ex_hold_i, ex_jump_i, mem_stall_i, trap_i, clr_i;
    logic [STAGES-1:0] stall_o, flush_o;
    logic              hold_timeout_o;
    logic [CNT_W-1:0]  stall_cyc_o, flush_cyc_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    int               m_tail_left = 0;
    logic [4:0]       m_tail_pat  = '0;
    int               m_run       = 0;
    logic             m_to        = 1'b0;
    int               m_sc        = 0;
    int               m_fc        = 0;

    pipe_hold_ctrl #(
        .STAGES(STAGES), .ID_IDX(2), .EX_IDX(3), .MEM_IDX(4),
        .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .prd_jump_i(prd_jump_i), .ex_hold_i(ex_hold_i), .ex_jump_i(ex_jump_i),
        .mem_stall_i(mem_stall_i), .trap_i(trap_i), .clr_i(clr_i),
        .stall_o(stall_o), .flush_o(flush_o), .hold_timeout_o(hold_timeout_o),
        .stall_cyc_o(stall_cyc_o), .flush_cyc_o(flush_cyc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [4:0] rng(input int hi, input int lo);
        logic [4:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic drive(input logic r, input logic tr, input logic ej, input logic ms,
                         input logic eh, input logic pj, input logic cl);
        logic [4:0] wf, ws, ef, es;
        logic       rs;
        @(posedge clk);
        #1;
        rstn = r; trap_i = tr; ex_jump_i = ej; mem_stall_i = ms;
        ex_hold_i = eh; prd_jump_i = pj; clr_i = cl;
        #3;
        cyc++;
        wf = '0; ws = '0; rs = 1'b0;
        if (tr) begin wf = rng(4, 1); rs = 1'b1; end
        else if (ej) begin wf = rng(2, 1); rs = 1'b1; end
        else if (ms) begin ws = rng(3, 0); wf = 5'b10000; end
        else if (eh) begin ws = rng(2, 0); wf = 5'b01000; end
        else if (pj && m_tail_left == 0) wf = 5'b00010;
        ef = wf | ((m_tail_left > 0) ? m_tail_pat : 5'b0);
        es = ws & ~ef;
        if (!r) begin ef = '0; es = '0; end

        $display("cyc=%0d rstn=%b tr=%b ej=%b ms=%b eh=%b pj=%b clr=%b stall=%b flush=%b to=%b sc=%0d fc=%0d",
                 cyc, r, tr, ej, ms, eh, pj, cl, stall_o, flush_o, hold_timeout_o,
                 stall_cyc_o, flush_cyc_o);
        check("stall", 32'(stall_o), 32'(es));
        check("flush", 32'(flush_o), 32'(ef));
        check("timeout", 32'(hold_timeout_o), 32'(m_to));
        check("stall_cyc", 32'(stall_cyc_o), 32'(m_sc));
        check("flush_cyc", 32'(flush_cyc_o), 32'(m_fc));

        if (!r) begin
            m_tail_left = 0; m_tail_pat = '0; m_run = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
        end else begin
            if (rs) begin
                m_tail_left = FLUSH_CYC - 1;
                m_tail_pat  = wf;
            end else if (m_tail_left > 0) begin
                m_tail_left--;
            end
            if (cl) begin
                m_run = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
            end else begin
                if (es != 0) begin
                    m_run = (m_run < TIMEOUT) ? m_run + 1 : TIMEOUT;
                    if (m_run == TIMEOUT) m_to = 1'b1;
                    if (m_sc < CNT_MAX) m_sc++;
                end else begin
                    m_run = 0;
                end
                if (ef != 0 && m_fc < CNT_MAX) m_fc++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rstn = 1'b0; prd_jump_i = 0; ex_hold_i = 0; ex_jump_i = 0;
        mem_stall_i = 0; trap_i = 0; clr_i = 0;

        do_reset();
        idle(10);
        check("tp_idle_stall", 32'(stall_o), 32'h0);
        check("tp_idle_sc", 32'(stall_cyc_o), 32'h0);

        drive(1, 0, 0, 0, 0, 1, 0);
        check("tp_prd_flush", 32'(flush_o), 32'h02);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_prd_fc", 32'(flush_cyc_o), 32'd1);
        check("tp_prd_off", 32'(flush_o), 32'h0);

        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0);
            check("tp_exh_stall", 32'(stall_o), 32'h07);
            check("tp_exh_flush", 32'(flush_o), 32'h08);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_exh_sc", 32'(stall_cyc_o), 32'd4);

        // ex_jump tail
        drive(1, 0, 1, 0, 0, 0, 0);
        check("tp_ej_t0", 32'(flush_o), 32'h06);
        drive(1, 0, 0, 0, 0, 1, 0);
        check("tp_ej_t1", 32'(flush_o), 32'h06);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_ej_t2", 32'(flush_o), 32'h06);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_ej_t3", 32'(flush_o), 32'h00);

        // ex_hold during the tail
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0);
        check("tp_ejh_stall", 32'(stall_o), 32'h01);
        check("tp_ejh_flush", 32'(flush_o), 32'h0e);
        idle(3);

        // trap restarts the tail
        drive(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, 0, 0, 0, 0, 0);
            check("tp_trap_tail", 32'(flush_o), 32'h1e);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_trap_end", 32'(flush_o), 32'h00);

        drive(1, 1, 0, 1, 0, 1, 0);
        check("tp_prio_flush", 32'(flush_o), 32'h1e);
        check("tp_prio_stall", 32'(stall_o), 32'h00);
        idle(3);

        // watchdog
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 0, 1, 0, 0, 0);
            if (i == 8) check("tp_wd_before", 32'(hold_timeout_o), 32'd0);
            if (i == 9) check("tp_wd_after", 32'(hold_timeout_o), 32'd1);
        end
        idle(2);
        check("tp_wd_sticky", 32'(hold_timeout_o), 32'd1);
        drive(1, 0, 0, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_clr_to", 32'(hold_timeout_o), 32'd0);
        check("tp_clr_sc", 32'(stall_cyc_o), 32'd0);
        drive(1, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        check("tp_rst_stall", 32'(stall_o), 32'h00);
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_rst_notail", 32'(flush_o), 32'h00);

        // long stall to hit counter saturation
        for (int i = 0; i < 70; i++) drive(1, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        check("tp_sat_sc", 32'(stall_cyc_o), 32'(CNT_MAX));

        begin
            logic ms, eh;
            ms = 0; eh = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 5) == 0) ms = ~ms;
                if ($urandom_range(0, 5) == 0) eh = ~eh;
                drive($urandom_range(0, 59) != 0,
                      $urandom_range(0, 15) == 0,
                      $urandom_range(0, 9) == 0,
                      ms, eh,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 39) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Parametrised pipeline hold/flush controller for the Deilt_RISCV core, successor to the fixed 5-bit hold generator. It arbitrates hold and flush requests from ID (predicted jump), EX (multi-cycle hold, mispredict redirect) and MEM (bus stall, trap). It drives separate per-register stall and flush vectors, stretches flushes over a configurable number of cycles, and keeps stall/flush performance counters plus a stall-timeout watchdog.

## Interface
- STAGES, 5: number of pipeline registers; bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB
- ID_IDX, 2: register written by ID (ID/EX)
- EX_IDX, 3: register written by EX (EX/MEM)
- MEM_IDX, 4: register written by MEM (MEM/WB)
- FLUSH_CYC, 1: total cycles a flush is held, ≥1
- TIMEOUT, 255: consecutive stall cycles before the watchdog fires, ≥1
- CNT_W, 32: performance counter width

Ports:
- clk  in  1  core clock
- rstn  in  1  reset rstn, synchronous, active-low
- prd_jump_i  in  1  ID predicted-taken jump
- ex_hold_i  in  1  EX multi-cycle hold (mul/div), level
- ex_jump_i  in  1  EX mispredict redirect, one-cycle pulse
- mem_stall_i  in  1  MEM bus wait, level
- trap_i  in  1  MEM trap/interrupt commit, one-cycle pulse
- clr_i  in  1  clears counters and sticky timeout
- stall_o  out  STAGES  1 = register k holds its value
- flush_o  out  STAGES  1 = register k loads a bubble
- hold_timeout_o  out  1  sticky watchdog flag
- stall_cyc_o  out  CNT_W  saturating count of cycles with any stall_o bit set
- flush_cyc_o  out  CNT_W  saturating count of cycles with any flush_o bit set

## Operation
- Request patterns, combinational in the request cycle:
  - trap: flush [MEM_IDX:1]
  - ex_jump: flush [EX_IDX-1:1]
  - mem_stall: stall [MEM_IDX-1:0], flush MEM_IDX
  - ex_hold: stall [EX_IDX-1:0], flush EX_IDX
  - prd_jump: flush bit 1 only; ID/EX is not flushed, so the predicted instruction reaches EX for checking.
- Priority: trap > ex_jump > mem_stall > ex_hold > prd_jump. Only the winner's pattern applies, except during the FLUSH tail (below).
- Bit 0 (PC) is never flushed. Where flush_o[k]=1, stall_o[k] is forced to 0.
- FSM has two states, IDLE and FLUSH.
  - From IDLE, a trap or ex_jump win with FLUSH_CYC>1 latches the flush pattern, loads the tail counter with FLUSH_CYC-1, and enters FLUSH.
  - In FLUSH, the latched flush pattern is reasserted each cycle and the counter decrements. The state returns to IDLE on the cycle the counter reaches 0.
  - A new trap or ex_jump in FLUSH relatches its pattern and reloads the counter (restart).
  - A stall request in FLUSH is ORed with the tail pattern, subject to the flush-over-stall rule.
  - prd_jump in FLUSH is ignored.
- Watchdog: a run counter increments on each cycle with |stall_o and clears on any cycle without a stall. When it equals TIMEOUT, hold_timeout_o sets and stays set until clr_i or reset. The run counter saturates at TIMEOUT.
- Performance counters increment per qualifying cycle and saturate at all-ones. clr_i zeroes them, the run counter and hold_timeout_o on the next edge; clr_i wins over a same-cycle increment.

## Timing
- stall_o and flush_o are combinational from inputs and state, valid the same cycle as the request, with zero latency.
- The FLUSH tail covers cycles 2..FLUSH_CYC after the request.
- State, counters and hold_timeout_o update on the clk rising edge.
- Reset: while rstn=0, stall_o=0 and flush_o=0 combinationally. On the reset edge: state=IDLE, tail counter=0, run counter=0, hold_timeout_o=0, stall_cyc_o=0, flush_cyc_o=0.
- Reset mid-FLUSH or mid-stall aborts immediately; no tail follows reset release.
- Level requests (ex_hold, mem_stall) produce their pattern every cycle they are high. Releasing the request releases the stall in the same cycle.

## Test plan
- Reset then idle: all inputs 0 → stall_o=00000, flush_o=00000, all counters 0; values hold through 10 cycles.
- prd_jump_i pulse → flush_o=00010, stall_o=00000 for one cycle; flush_cyc_o=1 after.
- ex_hold_i high for 4 cycles → stall_o=00111, flush_o=01000 each cycle; stall_cyc_o=4.
- FLUSH_CYC=3, ex_jump_i pulse at cycle t → flush_o=00110 at t, t+1, t+2 and 00000 at t+3. With ex_hold_i high at t+1, that cycle gives stall_o=00001, flush_o=01110. A trap_i at t+1 instead gives flush_o=11110 at t+1..t+3.
- Simultaneous trap_i, mem_stall_i and prd_jump_i → flush_o=11110, stall_o=00000.
- TIMEOUT=8, mem_stall_i high for 10 cycles → hold_timeout_o rises after the 8th stall cycle and stays high. clr_i → flag 0 and stall_cyc_o=0 next cycle. rstn low mid-stall → outputs 0 immediately.
